// File: rtl/jtframe_rom_pkg.sv
// Shared types for the multi-slot ROM front-end: FSM encoding, slot index width and address mapping.
// Latency: none (types and pure function only).
// Backpressure: n/a.
package jtframe_rom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } rom_st_t;

    localparam int MAX_SLOTS = 4;
    localparam int SLOT_IW   = 2;
    localparam int SDRAM_AW  = 22;

    // Maps a slot address onto the 16-bit word grid of the SDRAM bank.
    // Byte slots drop the byte select bit, 32-bit slots span two words.
    function automatic logic [SDRAM_AW-1:0] wordaddr(input logic [31:0] addr, input int dw);
        case (dw)
            8:       return addr[SDRAM_AW:1];
            32:      return {addr[SDRAM_AW-2:0], 1'b0};
            default: return addr[SDRAM_AW-1:0];
        endcase
    endfunction

endpackage

// File: rtl/jtframe_rom_slot_cache.sv
// One ROM slot: single-entry tag/data cache, hit compare, byte select and burst word capture.
// Latency: hit is combinational from addr/cs; a fill completes on the data_rdy cycle.
// Backpressure: none; the slot holds its miss request until the arbiter starts its fill.
module jtframe_rom_slot_cache
    import jtframe_rom_pkg::*;
#(
    parameter int                  AW     = 18,
    parameter int                  DW     = 8,
    parameter logic [SDRAM_AW-1:0] OFFSET = '0
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       addr,
    input  logic                cs,
    output logic                ok,
    output logic [DW-1:0]       dout,
    output logic                miss,
    output logic [SDRAM_AW-1:0] req_addr,
    input  logic                start,
    input  logic                we,
    input  logic                done,
    input  logic [15:0]         wr_dat
);

    logic [SDRAM_AW-1:0] word;
    logic [SDRAM_AW-1:0] tag;
    logic [SDRAM_AW-1:0] pend_tag;
    logic                valid;
    logic                half;
    logic [15:0]         data_lo;

    assign word     = wordaddr(32'(addr), DW);
    assign req_addr = word + OFFSET;
    assign ok       = cs & valid & (tag == word);
    assign miss     = cs & ~ok;

    // Tag bookkeeping: a fill invalidates the entry until its last word lands, and the
    // tag written is the one captured at fill start, not whatever addr shows at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            tag      <= '0;
            pend_tag <= '0;
        end else if (start) begin
            valid    <= 1'b0;
            pend_tag <= word;
        end else if (done) begin
            valid    <= 1'b1;
            tag      <= pend_tag;
        end
    end

    // Burst capture: half selects the lane the next word of a 32-bit fill goes to.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_lo <= '0;
            half    <= 1'b0;
        end else begin
            if (start) begin
                half <= 1'b0;
            end else if (we && DW == 32) begin
                half <= ~half;
            end
            if (we && !half) begin
                data_lo <= wr_dat;
            end
        end
    end

    generate
        if (DW == 32) begin : g_w32
            logic [15:0] data_hi;

            // High half only moves on the second word; a short burst leaves it stale.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_hi <= '0;
                end else if (we && half) begin
                    data_hi <= wr_dat;
                end
            end

            assign dout = {data_hi, data_lo};

            // The controller must deliver two words for a 32-bit slot, the last one with data_rdy.
            a_two_words : assert property (@(posedge clk) disable iff (rst) done |-> (we && half));
        end else if (DW == 16) begin : g_w16
            assign dout = data_lo;
        end else begin : g_w8
            assign dout = addr[0] ? data_lo[15:8] : data_lo[7:0];
        end
    endgenerate

endmodule

// File: rtl/jtframe_rom_nslots.sv
// SDRAM bank front-end: 1..4 cached read-only ROM slots arbitrated onto one request/ack port.
// Latency: hits are combinational; a miss issues sdram_req one cycle after cs (LATCH=1) or the same cycle (LATCH=0).
// Backpressure: sdram_req is held with a stable address until sdram_ack; one fetch in flight. Build option: JTFRAME_ROMSLOT_RR_EN.
module jtframe_rom_nslots
    import jtframe_rom_pkg::*;
#(
    parameter int          SLOTS        = 2,
    parameter int          SLOT0_AW     = 18,
    parameter int          SLOT1_AW     = 18,
    parameter int          SLOT2_AW     = 18,
    parameter int          SLOT3_AW     = 18,
    parameter int          SLOT0_DW     = 8,
    parameter int          SLOT1_DW     = 8,
    parameter int          SLOT2_DW     = 8,
    parameter int          SLOT3_DW     = 8,
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0,
    parameter int          LATCH        = 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOT0_AW-1:0] slot0_addr,
    input  logic [SLOT1_AW-1:0] slot1_addr,
    input  logic [SLOT2_AW-1:0] slot2_addr,
    input  logic [SLOT3_AW-1:0] slot3_addr,
    input  logic                slot0_cs,
    input  logic                slot1_cs,
    input  logic                slot2_cs,
    input  logic                slot3_cs,
    output logic                slot0_ok,
    output logic                slot1_ok,
    output logic                slot2_ok,
    output logic                slot3_ok,
    output logic [SLOT0_DW-1:0] slot0_dout,
    output logic [SLOT1_DW-1:0] slot1_dout,
    output logic [SLOT2_DW-1:0] slot2_dout,
    output logic [SLOT3_DW-1:0] slot3_dout,
    output logic [21:0]         sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);

    localparam logic [MAX_SLOTS-1:0] SLOT_EN = MAX_SLOTS'((1 << SLOTS) - 1);

    logic [MAX_SLOTS-1:0] miss_raw;
    logic [MAX_SLOTS-1:0] miss;
    logic [MAX_SLOTS-1:0] ok_raw;
    logic [MAX_SLOTS-1:0] start;
    logic [MAX_SLOTS-1:0] we;
    logic [MAX_SLOTS-1:0] done;
    logic [SDRAM_AW-1:0]  slot_addr [MAX_SLOTS];

    rom_st_t              st, st_nx;
    logic [SLOT_IW-1:0]   sel, sel_nx;
    logic [SDRAM_AW-1:0]  addr_q, addr_nx;
    logic                 req_q;
    logic                 grant_vld;
    logic [SLOT_IW-1:0]   grant_idx;

    jtframe_rom_slot_cache #(.AW(SLOT0_AW), .DW(SLOT0_DW), .OFFSET(SLOT0_OFFSET)) u_slot0 (
        .clk(clk), .rst(rst), .addr(slot0_addr), .cs(slot0_cs), .ok(ok_raw[0]), .dout(slot0_dout),
        .miss(miss_raw[0]), .req_addr(slot_addr[0]), .start(start[0]), .we(we[0]), .done(done[0]),
        .wr_dat(data_read)
    );

    jtframe_rom_slot_cache #(.AW(SLOT1_AW), .DW(SLOT1_DW), .OFFSET(SLOT1_OFFSET)) u_slot1 (
        .clk(clk), .rst(rst), .addr(slot1_addr), .cs(slot1_cs), .ok(ok_raw[1]), .dout(slot1_dout),
        .miss(miss_raw[1]), .req_addr(slot_addr[1]), .start(start[1]), .we(we[1]), .done(done[1]),
        .wr_dat(data_read)
    );

    jtframe_rom_slot_cache #(.AW(SLOT2_AW), .DW(SLOT2_DW), .OFFSET(SLOT2_OFFSET)) u_slot2 (
        .clk(clk), .rst(rst), .addr(slot2_addr), .cs(slot2_cs), .ok(ok_raw[2]), .dout(slot2_dout),
        .miss(miss_raw[2]), .req_addr(slot_addr[2]), .start(start[2]), .we(we[2]), .done(done[2]),
        .wr_dat(data_read)
    );

    jtframe_rom_slot_cache #(.AW(SLOT3_AW), .DW(SLOT3_DW), .OFFSET(SLOT3_OFFSET)) u_slot3 (
        .clk(clk), .rst(rst), .addr(slot3_addr), .cs(slot3_cs), .ok(ok_raw[3]), .dout(slot3_dout),
        .miss(miss_raw[3]), .req_addr(slot_addr[3]), .start(start[3]), .we(we[3]), .done(done[3]),
        .wr_dat(data_read)
    );

    // Slots beyond SLOTS never request and never report ok; their logic is left for synthesis to prune.
    assign miss     = miss_raw & SLOT_EN;
    assign slot0_ok = ok_raw[0] & SLOT_EN[0];
    assign slot1_ok = ok_raw[1] & SLOT_EN[1];
    assign slot2_ok = ok_raw[2] & SLOT_EN[2];
    assign slot3_ok = ok_raw[3] & SLOT_EN[3];

`ifdef JTFRAME_ROMSLOT_RR_EN
    logic [SLOT_IW-1:0] last;
    logic [SLOT_IW-1:0] cand;

    // Remember the last served slot; after reset slot0 is first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= SLOT_IW'(MAX_SLOTS - 1);
        end else if (st == ST_IDLE && grant_vld) begin
            last <= grant_idx;
        end
    end

    // Round-robin pick: scan starting from the slot after the last served one.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= MAX_SLOTS; k++) begin
            cand = last + SLOT_IW'(k);
            if (!grant_vld && miss[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end
`else
    // Fixed priority pick: the lowest-numbered missing slot wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = MAX_SLOTS - 1; k >= 0; k--) begin
            if (miss[k]) begin
                grant_vld = 1'b1;
                grant_idx = SLOT_IW'(k);
            end
        end
    end
`endif

    // FSM next state: latch the winner in IDLE, hold the request until ack, collect the burst.
    always_comb begin
        st_nx   = st;
        sel_nx  = sel;
        addr_nx = addr_q;
        case (st)
            ST_IDLE: begin
                if (grant_vld) begin
                    sel_nx  = grant_idx;
                    addr_nx = slot_addr[grant_idx];
                    st_nx   = (LATCH == 0 && sdram_ack) ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    st_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_rdy) begin
                    st_nx = ST_IDLE;
                end
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    // Per-slot fill strobes; burst words outside WAIT never reach a cache.
    always_comb begin
        start = '0;
        we    = '0;
        done  = '0;
        for (int n = 0; n < MAX_SLOTS; n++) begin
            start[n] = (st == ST_IDLE) && grant_vld && (grant_idx == SLOT_IW'(n));
            we[n]    = (st == ST_WAIT) && data_dst && (sel == SLOT_IW'(n));
            done[n]  = (st == ST_WAIT) && data_rdy && (sel == SLOT_IW'(n));
        end
    end

    // FSM and issue registers; req follows the state so it drops the cycle after ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_IDLE;
            sel    <= '0;
            addr_q <= '0;
            req_q  <= 1'b0;
        end else begin
            st     <= st_nx;
            sel    <= sel_nx;
            addr_q <= addr_nx;
            req_q  <= (st_nx == ST_REQ);
        end
    end

    // Controller-facing outputs: registered issue, or combinational issue straight from IDLE.
    always_comb begin
        if (LATCH != 0) begin
            sdram_req  = req_q;
            sdram_addr = addr_q;
        end else begin
            sdram_req  = (st == ST_REQ) || (st == ST_IDLE && grant_vld);
            sdram_addr = (st == ST_IDLE && grant_vld) ? slot_addr[grant_idx] : addr_q;
        end
    end

endmodule
